register_write_bank: RTL and testbench

REGISTER_WRITE_BANK -- requirements
Module: register_write_bank

---
 rtl/regfile_pkg.sv | 16 +
 rtl/decoder_5to32.sv | 18 +
 rtl/register_write_bank.sv | 143 ++++++++++++++
 tb/tb_register_write_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, used by the write bank, the index decoder and the 32:1 read mux.
// Holds no logic, so it adds no latency and has no backpressure.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int SEL_W    = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;

    typedef logic [SEL_W-1:0]    reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_sel_t;
    typedef logic [CNT_W-1:0]    wr_cnt_t;

    localparam wr_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/decoder_5to32.sv
// Decodes a 5-bit register index into a one-hot select, forced to all zeros when the enable is low.
// Purely combinational: zero latency, no backpressure.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/register_write_bank.sv
// Write port of a 32-entry register file, plus a write acknowledge and a saturating commit counter.
// Writes land on the clk edge and appear one cycle later, with no bypass; writes are always accepted.
module register_write_bank
    import regfile_pkg::NUM_REGS, regfile_pkg::SEL_W, regfile_pkg::CNT_W, regfile_pkg::CNT_MAX;
#(
    parameter int DATA_W  = 32,
    parameter int ZERO_R0 = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WriteEnable,
    input  logic [SEL_W-1:0]  WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] R6,
    output logic [DATA_W-1:0] R7,
    output logic [DATA_W-1:0] R8,
    output logic [DATA_W-1:0] R9,
    output logic [DATA_W-1:0] R10,
    output logic [DATA_W-1:0] R11,
    output logic [DATA_W-1:0] R12,
    output logic [DATA_W-1:0] R13,
    output logic [DATA_W-1:0] R14,
    output logic [DATA_W-1:0] R15,
    output logic [DATA_W-1:0] R16,
    output logic [DATA_W-1:0] R17,
    output logic [DATA_W-1:0] R18,
    output logic [DATA_W-1:0] R19,
    output logic [DATA_W-1:0] R20,
    output logic [DATA_W-1:0] R21,
    output logic [DATA_W-1:0] R22,
    output logic [DATA_W-1:0] R23,
    output logic [DATA_W-1:0] R24,
    output logic [DATA_W-1:0] R25,
    output logic [DATA_W-1:0] R26,
    output logic [DATA_W-1:0] R27,
    output logic [DATA_W-1:0] R28,
    output logic [DATA_W-1:0] R29,
    output logic [DATA_W-1:0] R30,
    output logic [DATA_W-1:0] R31,
    output logic              WriteAck,
    output logic [SEL_W-1:0]  AckReg,
    output logic [CNT_W-1:0]  WriteCount
);

    logic [NUM_REGS-1:0] w_sel;
    logic [NUM_REGS-1:0] w_sel_eff;
    logic                w_commit;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_ack;
    logic [SEL_W-1:0]    r_ack_reg;
    logic [CNT_W-1:0]    r_cnt;

    decoder_5to32 u_decoder (
        .i_sel    (WriteReg),
        .i_en     (WriteEnable),
        .o_onehot (w_sel)
    );

    // A masked R0 select means an index-0 write commits nothing, so it also raises no ack and no count.
    always_comb begin
        w_sel_eff = w_sel;
        if (ZERO_R0 != 0) begin
            w_sel_eff[0] = 1'b0;
        end
    end

    assign w_commit = |w_sel_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sel_eff[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_ack_reg <= '0;
            r_cnt     <= '0;
        end else begin
            r_ack <= w_commit;
            if (w_commit) begin
                r_ack_reg <= WriteReg;
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign WriteAck   = r_ack;
    assign AckReg     = r_ack_reg;
    assign WriteCount = r_cnt;

    assign R0  = (ZERO_R0 != 0) ? '0 : r_regs[0];
    assign R1  = r_regs[1];
    assign R2  = r_regs[2];
    assign R3  = r_regs[3];
    assign R4  = r_regs[4];
    assign R5  = r_regs[5];
    assign R6  = r_regs[6];
    assign R7  = r_regs[7];
    assign R8  = r_regs[8];
    assign R9  = r_regs[9];
    assign R10 = r_regs[10];
    assign R11 = r_regs[11];
    assign R12 = r_regs[12];
    assign R13 = r_regs[13];
    assign R14 = r_regs[14];
    assign R15 = r_regs[15];
    assign R16 = r_regs[16];
    assign R17 = r_regs[17];
    assign R18 = r_regs[18];
    assign R19 = r_regs[19];
    assign R20 = r_regs[20];
    assign R21 = r_regs[21];
    assign R22 = r_regs[22];
    assign R23 = r_regs[23];
    assign R24 = r_regs[24];
    assign R25 = r_regs[25];
    assign R26 = r_regs[26];
    assign R27 = r_regs[27];
    assign R28 = r_regs[28];
    assign R29 = r_regs[29];
    assign R30 = r_regs[30];
    assign R31 = r_regs[31];

endmodule

// File: tb/tb_register_write_bank.sv
// Bench for register_write_bank: one instance with R0 hardwired to zero (a), one with R0 writable (b).
// Both instances share the stimulus; a scoreboard tracks the expected contents of each.
module tb_register_write_bank;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdat;

    logic [31:0] ra [32];
    logic [31:0] rb [32];
    logic        ack_a, ack_b;
    logic [4:0]  ackreg_a, ackreg_b;
    logic [15:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic        m_ack_a, m_ack_b;
    logic [4:0]  m_ackreg_a, m_ackreg_b;
    int          m_cnt_a, m_cnt_b;

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        exp_ack;
        logic [4:0]  exp_ackreg;
        logic [31:0] exp_rval;
    } vec_t;
    vec_t vecs [7];

    register_write_bank #(.DATA_W(32), .ZERO_R0(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .WriteEnable(we), .WriteReg(widx), .WriteData(wdat),
        .R0(ra[0]),   .R1(ra[1]),   .R2(ra[2]),   .R3(ra[3]),
        .R4(ra[4]),   .R5(ra[5]),   .R6(ra[6]),   .R7(ra[7]),
        .R8(ra[8]),   .R9(ra[9]),   .R10(ra[10]), .R11(ra[11]),
        .R12(ra[12]), .R13(ra[13]), .R14(ra[14]), .R15(ra[15]),
        .R16(ra[16]), .R17(ra[17]), .R18(ra[18]), .R19(ra[19]),
        .R20(ra[20]), .R21(ra[21]), .R22(ra[22]), .R23(ra[23]),
        .R24(ra[24]), .R25(ra[25]), .R26(ra[26]), .R27(ra[27]),
        .R28(ra[28]), .R29(ra[29]), .R30(ra[30]), .R31(ra[31]),
        .WriteAck(ack_a), .AckReg(ackreg_a), .WriteCount(cnt_a)
    );

    register_write_bank #(.DATA_W(32), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .WriteEnable(we), .WriteReg(widx), .WriteData(wdat),
        .R0(rb[0]),   .R1(rb[1]),   .R2(rb[2]),   .R3(rb[3]),
        .R4(rb[4]),   .R5(rb[5]),   .R6(rb[6]),   .R7(rb[7]),
        .R8(rb[8]),   .R9(rb[9]),   .R10(rb[10]), .R11(rb[11]),
        .R12(rb[12]), .R13(rb[13]), .R14(rb[14]), .R15(rb[15]),
        .R16(rb[16]), .R17(rb[17]), .R18(rb[18]), .R19(rb[19]),
        .R20(rb[20]), .R21(rb[21]), .R22(rb[22]), .R23(rb[23]),
        .R24(rb[24]), .R25(rb[25]), .R26(rb[26]), .R27(rb[27]),
        .R28(rb[28]), .R29(rb[29]), .R30(rb[30]), .R31(rb[31]),
        .WriteAck(ack_b), .AckReg(ackreg_b), .WriteCount(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        m_ack_a = 1'b0; m_ack_b = 1'b0;
        m_ackreg_a = '0; m_ackreg_b = '0;
        m_cnt_a = 0; m_cnt_b = 0;
    endtask

    // Drives one write-port cycle and advances the scoreboard past that edge.
    task automatic drive_cycle(input logic e, input logic [4:0] idx, input logic [31:0] d);
        we = e; widx = idx; wdat = d;
        @(posedge clk);
        #1;
        m_ack_a = 1'b0;
        m_ack_b = 1'b0;
        if (e) begin
            if (idx != 5'd0) begin
                ma[idx] = d;
                m_ack_a = 1'b1;
                m_ackreg_a = idx;
                if (m_cnt_a < 65535) m_cnt_a++;
            end
            mb[idx] = d;
            m_ack_b = 1'b1;
            m_ackreg_b = idx;
            if (m_cnt_b < 65535) m_cnt_b++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s a.R%0d", tag, i), ra[i], ma[i]);
            chk($sformatf("%s b.R%0d", tag, i), rb[i], mb[i]);
        end
        chk({tag, " a.WriteAck"},   {31'd0, ack_a},    {31'd0, m_ack_a});
        chk({tag, " b.WriteAck"},   {31'd0, ack_b},    {31'd0, m_ack_b});
        chk({tag, " a.AckReg"},     {27'd0, ackreg_a}, {27'd0, m_ackreg_a});
        chk({tag, " b.AckReg"},     {27'd0, ackreg_b}, {27'd0, m_ackreg_b});
        chk({tag, " a.WriteCount"}, {16'd0, cnt_a},    m_cnt_a);
        chk({tag, " b.WriteCount"}, {16'd0, cnt_b},    m_cnt_b);
    endtask

    task automatic step(input logic e, input logic [4:0] idx, input logic [31:0] d, input string tag);
        drive_cycle(e, idx, d);
        check_all(tag);
    endtask

    initial begin
        int pulses;

        vecs[0] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd3,  32'hA5A5A5A5};
        vecs[1] = '{1'b0, 5'd3,  32'h00000000, 1'b0, 5'd3,  32'hA5A5A5A5};
        vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd3,  32'h00000000};
        vecs[3] = '{1'b1, 5'd31, 32'h12345678, 1'b1, 5'd31, 32'h12345678};
        vecs[4] = '{1'b1, 5'd31, 32'h87654321, 1'b1, 5'd31, 32'h87654321};
        vecs[5] = '{1'b0, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd31, 32'h87654321};
        vecs[6] = '{1'b1, 5'd16, 32'h0000FFFF, 1'b1, 5'd16, 32'h0000FFFF};

        rst_n = 1'b0; we = 1'b0; widx = '0; wdat = '0;
        model_reset();
        #2;
        check_all("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            drive_cycle(vecs[v].we, vecs[v].idx, vecs[v].data);
            chk($sformatf("vec%0d ack", v),    {31'd0, ack_a},    {31'd0, vecs[v].exp_ack});
            chk($sformatf("vec%0d ackreg", v), {27'd0, ackreg_a}, {27'd0, vecs[v].exp_ackreg});
            chk($sformatf("vec%0d rval", v),   ra[vecs[v].idx],   vecs[v].exp_rval);
            check_all($sformatf("vec%0d", v));
        end
        chk("table a.WriteCount", {16'd0, cnt_a}, 32'd4);
        chk("table b.R0", rb[0], 32'hDEADBEEF);
        chk("table b.WriteCount", {16'd0, cnt_b}, 32'd5);

        // Reset mid-run with an ack pulse in flight.
        step(1'b1, 5'd5, 32'h0BADF00D, "pre_reset");
        chk("pre_reset ack high", {31'd0, ack_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        drive_cycle(1'b1, 5'd9, 32'h00000055);
        model_reset();
        check_all("write_in_reset");
        rst_n = 1'b1;
        step(1'b1, 5'd9, 32'h00000055, "first_after_reset");
        chk("first_after_reset R9", ra[9], 32'h00000055);

        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 1; n < 32; n++) begin
            step(1'b1, n[4:0], 32'h1 << n, $sformatf("walk%0d", n));
            if (ack_a === 1'b1) pulses++;
        end
        chk("walk ack pulses", pulses, 32'd31);
        chk("walk WriteCount", {16'd0, cnt_a}, 32'd31);
        chk("walk R17", ra[17], 32'h00020000);

        step(1'b1, 5'd0, 32'hDEADBEEF, "r0_guard");
        chk("r0_guard a.R0", ra[0], 32'h0);
        chk("r0_guard a.ack", {31'd0, ack_a}, 32'd0);
        chk("r0_guard a.count", {16'd0, cnt_a}, 32'd31);
        chk("r0_guard b.R0", rb[0], 32'hDEADBEEF);

        for (int n = 0; n < 32; n++) begin
            step(1'b0, n[4:0], 32'hFFFFFFFF, $sformatf("gate%0d", n));
        end
        chk("gate a.ack", {31'd0, ack_a}, 32'd0);

        step(1'b1, 5'd7, 32'd5, "b2b_first");
        chk("b2b first ack", {31'd0, ack_a}, 32'd1);
        chk("b2b first ackreg", {27'd0, ackreg_a}, 32'd7);
        step(1'b1, 5'd7, 32'd9, "b2b_second");
        chk("b2b second ack", {31'd0, ack_a}, 32'd1);
        chk("b2b second ackreg", {27'd0, ackreg_a}, 32'd7);
        chk("b2b R7", ra[7], 32'd9);
        step(1'b0, 5'd2, 32'd0, "b2b_idle");
        chk("b2b idle ack", {31'd0, ack_a}, 32'd0);
        chk("b2b idle ackreg held", {27'd0, ackreg_a}, 32'd7);

        for (int n = 0; n < 65540; n++) begin
            drive_cycle(1'b1, 5'd1, n);
        end
        check_all("saturate");
        chk("saturate a.count", {16'd0, cnt_a}, 32'h0000FFFF);
        step(1'b1, 5'd2, 32'h13572468, "sat_hold1");
        step(1'b1, 5'd3, 32'h24681357, "sat_hold2");
        chk("saturate hold a.count", {16'd0, cnt_a}, 32'h0000FFFF);
        chk("saturate hold b.count", {16'd0, cnt_b}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
